// File: rtl/cp_id_ex_pipe_pkg.sv
// Shared CP definitions used by the ID/EX stage: datapath widths,
// control-bundle field widths and the encodings that make up a pipeline bubble.
package cp_id_ex_pipe_pkg;

   localparam int CP_DATA_WIDTH         = 32;
   localparam int CP_RF_INDEX_WIDTH     = 5;
   localparam int CP_I_MEM_ADDR_WIDTH   = 16;
   localparam int CP_PC_WIDTH           = CP_I_MEM_ADDR_WIDTH - 2;

   localparam int CP_ALU_OP_WIDTH       = 4;
   localparam int CP_MULSHLOG_OP_WIDTH  = 3;
   localparam int CP_WRITEBACK_WIDTH    = 2;

   localparam logic [CP_ALU_OP_WIDTH-1:0]      RISC24_CP_ALU_OP_ADD      = 4'b0001;
   localparam logic [CP_MULSHLOG_OP_WIDTH-1:0] RISC24_CP_MULSHLOG_OP_AND = 3'b100;

   // Bit 0 of the writeback field is the register-file write enable.
   localparam logic [CP_WRITEBACK_WIDTH-1:0]   CP_WB_NONE    = 2'b00;
   localparam logic [CP_WRITEBACK_WIDTH-1:0]   CP_WB_ALU     = 2'b01;
   localparam logic [CP_WRITEBACK_WIDTH-1:0]   CP_WB_MULSHLOG = 2'b11;

endpackage

// File: rtl/cp_id_ex_pipe_fwd_mux.sv
// Operand forwarding select for one source index: the EX result, then the
// register-file write port, then the raw register-file read data.
module cp_fwd_mux #(
   parameter int DATA_W = 32,
   parameter int RFI_W  = 5
) (
   input  logic [RFI_W-1:0]  iAddr,
   input  logic [DATA_W-1:0] iRawData,
   input  logic [DATA_W-1:0] iExData,
   input  logic [RFI_W-1:0]  iExAddr,
   input  logic              iExEnable,
   input  logic [DATA_W-1:0] iWbData,
   input  logic [RFI_W-1:0]  iWbAddr,
   input  logic              iWbEnable,
   output logic [DATA_W-1:0] oData
);

   // EX holds the newer value, so it wins when both stages target this index.
   always_comb begin
      oData = iRawData;
      if (iExEnable && (iExAddr == iAddr)) begin
         oData = iExData;
      end else if (iWbEnable && (iWbAddr == iAddr)) begin
         oData = iWbData;
      end
   end

endmodule

// File: rtl/cp_id_ex_pipe.sv
// ID/EX pipeline register of the CP. Forwards EX/WB results onto the source
// operands, supports stall, bubble insertion and per-unit operand hold.
module cp_id_ex_pipe
   import cp_id_ex_pipe_pkg::*;
#(
   parameter int DATA_W = CP_DATA_WIDTH,
   parameter int RFI_W  = CP_RF_INDEX_WIDTH,
   parameter int PC_W   = CP_PC_WIDTH
) (
   input  logic                            iClk,
   input  logic                            iReset,
   input  logic                            iStall,
   input  logic                            iFlush,
   input  logic                            iDEC_Valid,
   input  logic [RFI_W-1:0]                iDEC_RF_Read_Addr_A,
   input  logic [RFI_W-1:0]                iDEC_RF_Read_Addr_B,
   input  logic [DATA_W-1:0]               iDEC_RF_Read_Data_A,
   input  logic [DATA_W-1:0]               iDEC_RF_Read_Data_B,
   input  logic                            iDEC_B_Is_Imm,
   input  logic [DATA_W-1:0]               iDEC_Imm,
   input  logic                            iDEC_Is_ALU,
   input  logic                            iDEC_Is_MULSHLOG,
   input  logic                            iDEC_Is_Multiplication,
   input  logic                            iDEC_Is_Shift,
   input  logic [CP_ALU_OP_WIDTH-1:0]      iDEC_ALU_Opcode,
   input  logic [CP_MULSHLOG_OP_WIDTH-1:0] iDEC_MULSHLOG_Opcode,
   input  logic [CP_WRITEBACK_WIDTH-1:0]   iDEC_RF_WriteBack,
   input  logic [RFI_W-1:0]                iDEC_RF_Write_Addr,
   input  logic                            iDEC_Update_Flag,
   input  logic                            iDEC_Update_P0,
   input  logic                            iDEC_Update_P1,
   input  logic [PC_W-1:0]                 iDEC_PC,
   input  logic [DATA_W-1:0]               iEX_Fwd_Data,
   input  logic [RFI_W-1:0]                iEX_Fwd_Addr,
   input  logic                            iEX_Fwd_Enable,
   input  logic [DATA_W-1:0]               iWB_Data,
   input  logic [RFI_W-1:0]                iWB_Addr,
   input  logic                            iWB_Enable,
   output logic [CP_ALU_OP_WIDTH-1:0]      oID_EX_ALU_Opcode,
   output logic [DATA_W-1:0]               oID_EX_ALU_Operand_A,
   output logic [DATA_W-1:0]               oID_EX_ALU_Operand_B,
   output logic [CP_MULSHLOG_OP_WIDTH-1:0] oID_EX_MULSHLOG_Opcode,
   output logic [DATA_W-1:0]               oID_EX_MULSHLOG_Operand_A,
   output logic [DATA_W-1:0]               oID_EX_MULSHLOG_Operand_B,
   output logic                            oID_EX_Is_Multiplication,
   output logic                            oID_EX_Is_Shift,
   output logic [RFI_W-1:0]                oID_EX_RF_Write_Addr,
   output logic [CP_WRITEBACK_WIDTH-1:0]   oID_EX_RF_WriteBack,
   output logic                            oID_EX_Update_Flag,
   output logic                            oID_EX_Update_P0,
   output logic                            oID_EX_Update_P1,
   output logic [PC_W-1:0]                 oID_EX_PC,
   output logic                            oID_EX_Valid
);

   logic [DATA_W-1:0] fwdA;
   logic [DATA_W-1:0] fwdB;
   logic [DATA_W-1:0] operandB;
   logic              load;
   logic              bubble;

   cp_fwd_mux #(.DATA_W(DATA_W), .RFI_W(RFI_W)) uFwdA (
      .iAddr     (iDEC_RF_Read_Addr_A),
      .iRawData  (iDEC_RF_Read_Data_A),
      .iExData   (iEX_Fwd_Data),
      .iExAddr   (iEX_Fwd_Addr),
      .iExEnable (iEX_Fwd_Enable),
      .iWbData   (iWB_Data),
      .iWbAddr   (iWB_Addr),
      .iWbEnable (iWB_Enable),
      .oData     (fwdA)
   );

   cp_fwd_mux #(.DATA_W(DATA_W), .RFI_W(RFI_W)) uFwdB (
      .iAddr     (iDEC_RF_Read_Addr_B),
      .iRawData  (iDEC_RF_Read_Data_B),
      .iExData   (iEX_Fwd_Data),
      .iExAddr   (iEX_Fwd_Addr),
      .iExEnable (iEX_Fwd_Enable),
      .iWbData   (iWB_Data),
      .iWbAddr   (iWB_Addr),
      .iWbEnable (iWB_Enable),
      .oData     (fwdB)
   );

   assign operandB = iDEC_B_Is_Imm ? iDEC_Imm : fwdB;

   // Flush overrides stall; an idle decoder also turns into a bubble.
   assign bubble = iFlush | (~iStall & ~iDEC_Valid);
   assign load   = ~iStall & iDEC_Valid & ~iFlush;

   // Control bundle: bubble values on reset/bubble, decoded values on load.
   always_ff @(posedge iClk) begin
      if (iReset || bubble) begin
         oID_EX_ALU_Opcode        <= RISC24_CP_ALU_OP_ADD;
         oID_EX_MULSHLOG_Opcode   <= RISC24_CP_MULSHLOG_OP_AND;
         oID_EX_Is_Multiplication <= 1'b0;
         oID_EX_Is_Shift          <= 1'b0;
         oID_EX_RF_WriteBack      <= CP_WB_NONE;
         oID_EX_Update_Flag       <= 1'b0;
         oID_EX_Update_P0         <= 1'b0;
         oID_EX_Update_P1         <= 1'b0;
         oID_EX_Valid             <= 1'b0;
      end else if (load) begin
         oID_EX_ALU_Opcode        <= iDEC_ALU_Opcode;
         oID_EX_MULSHLOG_Opcode   <= iDEC_MULSHLOG_Opcode;
         oID_EX_Is_Multiplication <= iDEC_Is_Multiplication;
         oID_EX_Is_Shift          <= iDEC_Is_Shift;
         oID_EX_RF_WriteBack      <= iDEC_RF_WriteBack;
         oID_EX_Update_Flag       <= iDEC_Update_Flag;
         oID_EX_Update_P0         <= iDEC_Update_P0;
         oID_EX_Update_P1         <= iDEC_Update_P1;
         oID_EX_Valid             <= 1'b1;
      end
   end

   // Operands of the unit not targeted keep their value so its inputs do not toggle.
   always_ff @(posedge iClk) begin
      if (iReset) begin
         oID_EX_ALU_Operand_A      <= '0;
         oID_EX_ALU_Operand_B      <= '0;
         oID_EX_MULSHLOG_Operand_A <= '0;
         oID_EX_MULSHLOG_Operand_B <= '0;
      end else begin
         if (load && iDEC_Is_ALU) begin
            oID_EX_ALU_Operand_A <= fwdA;
            oID_EX_ALU_Operand_B <= operandB;
         end
         if (load && iDEC_Is_MULSHLOG) begin
            oID_EX_MULSHLOG_Operand_A <= fwdA;
            oID_EX_MULSHLOG_Operand_B <= operandB;
         end
      end
   end

   // PC and destination index only change with a real instruction.
   always_ff @(posedge iClk) begin
      if (iReset) begin
         oID_EX_PC            <= '0;
         oID_EX_RF_Write_Addr <= '0;
      end else if (load) begin
         oID_EX_PC            <= iDEC_PC;
         oID_EX_RF_Write_Addr <= iDEC_RF_Write_Addr;
      end
   end

endmodule

// File: tb/tb_cp_id_ex_pipe.sv
// Bench for cp_id_ex_pipe: forwarding vector table, hand-written stall/flush/
// isolation/reset sequences and a randomized run against a reference model.
module tb_cp_id_ex_pipe;
   import cp_id_ex_pipe_pkg::*;

   logic        iClk = 1'b0;
   logic        iReset, iStall, iFlush, iDEC_Valid;
   logic [4:0]  iDEC_RF_Read_Addr_A, iDEC_RF_Read_Addr_B;
   logic [31:0] iDEC_RF_Read_Data_A, iDEC_RF_Read_Data_B;
   logic        iDEC_B_Is_Imm;
   logic [31:0] iDEC_Imm;
   logic        iDEC_Is_ALU, iDEC_Is_MULSHLOG, iDEC_Is_Multiplication, iDEC_Is_Shift;
   logic [3:0]  iDEC_ALU_Opcode;
   logic [2:0]  iDEC_MULSHLOG_Opcode;
   logic [1:0]  iDEC_RF_WriteBack;
   logic [4:0]  iDEC_RF_Write_Addr;
   logic        iDEC_Update_Flag, iDEC_Update_P0, iDEC_Update_P1;
   logic [13:0] iDEC_PC;
   logic [31:0] iEX_Fwd_Data;
   logic [4:0]  iEX_Fwd_Addr;
   logic        iEX_Fwd_Enable;
   logic [31:0] iWB_Data;
   logic [4:0]  iWB_Addr;
   logic        iWB_Enable;

   logic [3:0]  oID_EX_ALU_Opcode;
   logic [31:0] oID_EX_ALU_Operand_A, oID_EX_ALU_Operand_B;
   logic [2:0]  oID_EX_MULSHLOG_Opcode;
   logic [31:0] oID_EX_MULSHLOG_Operand_A, oID_EX_MULSHLOG_Operand_B;
   logic        oID_EX_Is_Multiplication, oID_EX_Is_Shift;
   logic [4:0]  oID_EX_RF_Write_Addr;
   logic [1:0]  oID_EX_RF_WriteBack;
   logic        oID_EX_Update_Flag, oID_EX_Update_P0, oID_EX_Update_P1;
   logic [13:0] oID_EX_PC;
   logic        oID_EX_Valid;

   int checks = 0;
   int failures = 0;

   always #5 iClk = ~iClk;

   cp_id_ex_pipe dut (
      .iClk(iClk), .iReset(iReset), .iStall(iStall), .iFlush(iFlush),
      .iDEC_Valid(iDEC_Valid),
      .iDEC_RF_Read_Addr_A(iDEC_RF_Read_Addr_A), .iDEC_RF_Read_Addr_B(iDEC_RF_Read_Addr_B),
      .iDEC_RF_Read_Data_A(iDEC_RF_Read_Data_A), .iDEC_RF_Read_Data_B(iDEC_RF_Read_Data_B),
      .iDEC_B_Is_Imm(iDEC_B_Is_Imm), .iDEC_Imm(iDEC_Imm),
      .iDEC_Is_ALU(iDEC_Is_ALU), .iDEC_Is_MULSHLOG(iDEC_Is_MULSHLOG),
      .iDEC_Is_Multiplication(iDEC_Is_Multiplication), .iDEC_Is_Shift(iDEC_Is_Shift),
      .iDEC_ALU_Opcode(iDEC_ALU_Opcode), .iDEC_MULSHLOG_Opcode(iDEC_MULSHLOG_Opcode),
      .iDEC_RF_WriteBack(iDEC_RF_WriteBack), .iDEC_RF_Write_Addr(iDEC_RF_Write_Addr),
      .iDEC_Update_Flag(iDEC_Update_Flag), .iDEC_Update_P0(iDEC_Update_P0),
      .iDEC_Update_P1(iDEC_Update_P1), .iDEC_PC(iDEC_PC),
      .iEX_Fwd_Data(iEX_Fwd_Data), .iEX_Fwd_Addr(iEX_Fwd_Addr), .iEX_Fwd_Enable(iEX_Fwd_Enable),
      .iWB_Data(iWB_Data), .iWB_Addr(iWB_Addr), .iWB_Enable(iWB_Enable),
      .oID_EX_ALU_Opcode(oID_EX_ALU_Opcode),
      .oID_EX_ALU_Operand_A(oID_EX_ALU_Operand_A), .oID_EX_ALU_Operand_B(oID_EX_ALU_Operand_B),
      .oID_EX_MULSHLOG_Opcode(oID_EX_MULSHLOG_Opcode),
      .oID_EX_MULSHLOG_Operand_A(oID_EX_MULSHLOG_Operand_A),
      .oID_EX_MULSHLOG_Operand_B(oID_EX_MULSHLOG_Operand_B),
      .oID_EX_Is_Multiplication(oID_EX_Is_Multiplication), .oID_EX_Is_Shift(oID_EX_Is_Shift),
      .oID_EX_RF_Write_Addr(oID_EX_RF_Write_Addr), .oID_EX_RF_WriteBack(oID_EX_RF_WriteBack),
      .oID_EX_Update_Flag(oID_EX_Update_Flag), .oID_EX_Update_P0(oID_EX_Update_P0),
      .oID_EX_Update_P1(oID_EX_Update_P1), .oID_EX_PC(oID_EX_PC), .oID_EX_Valid(oID_EX_Valid)
   );

   // Expected contents of the EX slot.
   typedef struct packed {
      logic [3:0]  aluOp;
      logic [31:0] aluA;
      logic [31:0] aluB;
      logic [2:0]  mulOp;
      logic [31:0] mulA;
      logic [31:0] mulB;
      logic        isMul;
      logic        isShift;
      logic [4:0]  wAddr;
      logic [1:0]  wb;
      logic        uf;
      logic        u0;
      logic        u1;
      logic [13:0] pc;
      logic        valid;
   } exp_t;

   exp_t model;

   // Value an instruction in ID would see for a register index this cycle.
   function automatic logic [31:0] seenValue(input logic [4:0] idx, input logic [31:0] raw);
      if (iEX_Fwd_Enable && iEX_Fwd_Addr == idx) return iEX_Fwd_Data;
      if (iWB_Enable && iWB_Addr == idx) return iWB_Data;
      return raw;
   endfunction

   function automatic exp_t modelNext(input exp_t cur);
      exp_t        n;
      logic [31:0] a;
      logic [31:0] b;
      n = cur;
      a = seenValue(iDEC_RF_Read_Addr_A, iDEC_RF_Read_Data_A);
      b = iDEC_B_Is_Imm ? iDEC_Imm : seenValue(iDEC_RF_Read_Addr_B, iDEC_RF_Read_Data_B);
      if (iReset) begin
         n = '0;
         n.aluOp = RISC24_CP_ALU_OP_ADD;
         n.mulOp = RISC24_CP_MULSHLOG_OP_AND;
      end else if (iFlush || (!iStall && !iDEC_Valid)) begin
         n.aluOp = RISC24_CP_ALU_OP_ADD;
         n.mulOp = RISC24_CP_MULSHLOG_OP_AND;
         n.isMul = 1'b0; n.isShift = 1'b0;
         n.wb = 2'b00; n.uf = 1'b0; n.u0 = 1'b0; n.u1 = 1'b0;
         n.valid = 1'b0;
      end else if (!iStall) begin
         n.aluOp = iDEC_ALU_Opcode;   n.mulOp = iDEC_MULSHLOG_Opcode;
         n.isMul = iDEC_Is_Multiplication; n.isShift = iDEC_Is_Shift;
         n.wb = iDEC_RF_WriteBack;    n.wAddr = iDEC_RF_Write_Addr;
         n.uf = iDEC_Update_Flag;     n.u0 = iDEC_Update_P0; n.u1 = iDEC_Update_P1;
         n.pc = iDEC_PC;              n.valid = 1'b1;
         if (iDEC_Is_ALU) begin n.aluA = a; n.aluB = b; end
         if (iDEC_Is_MULSHLOG) begin n.mulA = a; n.mulB = b; end
      end
      return n;
   endfunction

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
   endtask

   task automatic checkAll(input string tag);
      cmp({tag, ".aluOp"}, 32'(oID_EX_ALU_Opcode), 32'(model.aluOp));
      cmp({tag, ".aluA"}, oID_EX_ALU_Operand_A, model.aluA);
      cmp({tag, ".aluB"}, oID_EX_ALU_Operand_B, model.aluB);
      cmp({tag, ".mulOp"}, 32'(oID_EX_MULSHLOG_Opcode), 32'(model.mulOp));
      cmp({tag, ".mulA"}, oID_EX_MULSHLOG_Operand_A, model.mulA);
      cmp({tag, ".mulB"}, oID_EX_MULSHLOG_Operand_B, model.mulB);
      cmp({tag, ".isMul"}, 32'(oID_EX_Is_Multiplication), 32'(model.isMul));
      cmp({tag, ".isShift"}, 32'(oID_EX_Is_Shift), 32'(model.isShift));
      cmp({tag, ".wAddr"}, 32'(oID_EX_RF_Write_Addr), 32'(model.wAddr));
      cmp({tag, ".wb"}, 32'(oID_EX_RF_WriteBack), 32'(model.wb));
      cmp({tag, ".uf"}, 32'(oID_EX_Update_Flag), 32'(model.uf));
      cmp({tag, ".u0"}, 32'(oID_EX_Update_P0), 32'(model.u0));
      cmp({tag, ".u1"}, 32'(oID_EX_Update_P1), 32'(model.u1));
      cmp({tag, ".pc"}, 32'(oID_EX_PC), 32'(model.pc));
      cmp({tag, ".valid"}, 32'(oID_EX_Valid), 32'(model.valid));
   endtask

   // Advance one clock, stepping the model with the inputs present before the edge.
   task automatic tick();
      model = modelNext(model);
      @(posedge iClk);
      #1;
   endtask

   task automatic clearInputs();
      iReset = 0; iStall = 0; iFlush = 0; iDEC_Valid = 0;
      iDEC_RF_Read_Addr_A = 0; iDEC_RF_Read_Addr_B = 0;
      iDEC_RF_Read_Data_A = 0; iDEC_RF_Read_Data_B = 0;
      iDEC_B_Is_Imm = 0; iDEC_Imm = 0;
      iDEC_Is_ALU = 0; iDEC_Is_MULSHLOG = 0; iDEC_Is_Multiplication = 0; iDEC_Is_Shift = 0;
      iDEC_ALU_Opcode = 0; iDEC_MULSHLOG_Opcode = 0; iDEC_RF_WriteBack = 0;
      iDEC_RF_Write_Addr = 0; iDEC_Update_Flag = 0; iDEC_Update_P0 = 0; iDEC_Update_P1 = 0;
      iDEC_PC = 0;
      iEX_Fwd_Data = 0; iEX_Fwd_Addr = 0; iEX_Fwd_Enable = 0;
      iWB_Data = 0; iWB_Addr = 0; iWB_Enable = 0;
   endtask

   typedef struct packed {
      logic [4:0]  addrA;
      logic [31:0] rawA;
      logic [4:0]  addrB;
      logic [31:0] rawB;
      logic        bImm;
      logic [31:0] imm;
      logic        exEn;
      logic [4:0]  exAddr;
      logic [31:0] exData;
      logic        wbEn;
      logic [4:0]  wbAddr;
      logic [31:0] wbData;
      logic [31:0] expA;
      logic [31:0] expB;
   } vec_t;

   vec_t vecs [7];

   initial begin
      //           aA  rawA           aB  rawB           imm? imm            ex  exA exData         wb  wbA wbData         expA           expB
      vecs[0] = '{5'd3, 32'h0,        5'd4, 32'h11,      1'b0, 32'h0,        1'b1, 5'd3, 32'h1234_5678, 1'b0, 5'd0, 32'h0,   32'h1234_5678, 32'h11};
      vecs[1] = '{5'd1, 32'h22,       5'd5, 32'h33,      1'b0, 32'h0,        1'b1, 5'd5, 32'hAA,   1'b1, 5'd5, 32'hBB,        32'h22,        32'hAA};
      vecs[2] = '{5'd1, 32'h22,       5'd5, 32'h33,      1'b0, 32'h0,        1'b0, 5'd5, 32'hAA,   1'b1, 5'd5, 32'hBB,        32'h22,        32'hBB};
      vecs[3] = '{5'd6, 32'h1,        5'd6, 32'h2,       1'b1, 32'hFFFF_FFF0, 1'b0, 5'd0, 32'h0,   1'b1, 5'd6, 32'h55,        32'h55,        32'hFFFF_FFF0};
      vecs[4] = '{5'd0, 32'h0,        5'd0, 32'h0,       1'b0, 32'h0,        1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'h0,         32'hDEAD,      32'hDEAD};
      vecs[5] = '{5'd7, 32'h1,        5'd8, 32'h2,       1'b0, 32'h0,        1'b1, 5'd8, 32'h88,   1'b1, 5'd7, 32'h77,        32'h77,        32'h88};
      vecs[6] = '{5'd9, 32'h99,       5'd10, 32'hA0,     1'b0, 32'h0,        1'b1, 5'd11, 32'h1,   1'b1, 5'd12, 32'h2,        32'h99,        32'hA0};

      model = '0;
      clearInputs();

      // Reset state.
      iReset = 1;
      tick();
      iReset = 0;
      cmp("rst.valid", 32'(oID_EX_Valid), 32'd0);
      cmp("rst.aluOp", 32'(oID_EX_ALU_Opcode), 32'(RISC24_CP_ALU_OP_ADD));
      cmp("rst.mulOp", 32'(oID_EX_MULSHLOG_Opcode), 32'(RISC24_CP_MULSHLOG_OP_AND));
      cmp("rst.aluA", oID_EX_ALU_Operand_A, 32'd0);
      cmp("rst.pc", 32'(oID_EX_PC), 32'd0);
      checkAll("rst");

      // Forwarding table.
      for (int i = 0; i < 7; i++) begin
         clearInputs();
         iDEC_Valid = 1; iDEC_Is_ALU = 1; iDEC_ALU_Opcode = 4'h2; iDEC_PC = 14'(i);
         iDEC_RF_Read_Addr_A = vecs[i].addrA; iDEC_RF_Read_Data_A = vecs[i].rawA;
         iDEC_RF_Read_Addr_B = vecs[i].addrB; iDEC_RF_Read_Data_B = vecs[i].rawB;
         iDEC_B_Is_Imm = vecs[i].bImm; iDEC_Imm = vecs[i].imm;
         iEX_Fwd_Enable = vecs[i].exEn; iEX_Fwd_Addr = vecs[i].exAddr; iEX_Fwd_Data = vecs[i].exData;
         iWB_Enable = vecs[i].wbEn; iWB_Addr = vecs[i].wbAddr; iWB_Data = vecs[i].wbData;
         tick();
         cmp($sformatf("vec%0d.aluA", i), oID_EX_ALU_Operand_A, vecs[i].expA);
         cmp($sformatf("vec%0d.aluB", i), oID_EX_ALU_Operand_B, vecs[i].expB);
         cmp($sformatf("vec%0d.valid", i), 32'(oID_EX_Valid), 32'd1);
      end

      // Stall for three cycles, then flush while still stalled.
      clearInputs();
      iDEC_Valid = 1; iDEC_Is_ALU = 1; iDEC_ALU_Opcode = 4'h5; iDEC_RF_WriteBack = CP_WB_ALU;
      iDEC_RF_Write_Addr = 5'd3; iDEC_PC = 14'h100; iDEC_Update_Flag = 1;
      iDEC_RF_Read_Addr_A = 5'd2; iDEC_RF_Read_Data_A = 32'h4321;
      iDEC_RF_Read_Addr_B = 5'd3; iDEC_RF_Read_Data_B = 32'h10;
      tick();
      cmp("ld.aluOp", 32'(oID_EX_ALU_Opcode), 32'h5);
      cmp("ld.aluA", oID_EX_ALU_Operand_A, 32'h4321);
      iStall = 1; iDEC_ALU_Opcode = 4'h2; iDEC_RF_Read_Data_A = 32'hFFFF; iDEC_PC = 14'h200;
      for (int c = 0; c < 3; c++) begin
         tick();
         cmp("stall.aluOp", 32'(oID_EX_ALU_Opcode), 32'h5);
         cmp("stall.aluA", oID_EX_ALU_Operand_A, 32'h4321);
         cmp("stall.pc", 32'(oID_EX_PC), 32'h100);
         cmp("stall.valid", 32'(oID_EX_Valid), 32'd1);
         checkAll("stall");
      end
      iFlush = 1;
      tick();
      cmp("flush.valid", 32'(oID_EX_Valid), 32'd0);
      cmp("flush.wb", 32'(oID_EX_RF_WriteBack), 32'd0);
      cmp("flush.aluOp", 32'(oID_EX_ALU_Opcode), 32'(RISC24_CP_ALU_OP_ADD));
      cmp("flush.aluA", oID_EX_ALU_Operand_A, 32'h4321);
      cmp("flush.pc", 32'(oID_EX_PC), 32'h100);
      checkAll("flush");

      // Operand isolation between units.
      clearInputs();
      iDEC_Valid = 1; iDEC_Is_ALU = 1; iDEC_RF_Read_Addr_A = 5'd1; iDEC_RF_Read_Data_A = 32'd7;
      tick();
      iDEC_Is_ALU = 0; iDEC_Is_MULSHLOG = 1; iDEC_Is_Multiplication = 1;
      iDEC_MULSHLOG_Opcode = 3'h1; iDEC_RF_Read_Data_A = 32'd9;
      tick();
      cmp("iso.aluA", oID_EX_ALU_Operand_A, 32'd7);
      cmp("iso.mulA", oID_EX_MULSHLOG_Operand_A, 32'd9);
      cmp("iso.isMul", 32'(oID_EX_Is_Multiplication), 32'd1);
      checkAll("iso");

      // Reset in the middle of a valid stream, then the first instruction after release.
      iStall = 1; iReset = 1;
      tick();
      cmp("mrst.valid", 32'(oID_EX_Valid), 32'd0);
      cmp("mrst.aluA", oID_EX_ALU_Operand_A, 32'd0);
      cmp("mrst.mulA", oID_EX_MULSHLOG_Operand_A, 32'd0);
      cmp("mrst.pc", 32'(oID_EX_PC), 32'd0);
      cmp("mrst.mulOp", 32'(oID_EX_MULSHLOG_Opcode), 32'(RISC24_CP_MULSHLOG_OP_AND));
      checkAll("mrst");
      iReset = 0; iStall = 0; iDEC_PC = 14'h22;
      tick();
      cmp("post.valid", 32'(oID_EX_Valid), 32'd1);
      cmp("post.pc", 32'(oID_EX_PC), 32'h22);
      checkAll("post");

      // Randomized run against the model.
      for (int n = 0; n < 400; n++) begin
         iReset = ($urandom_range(0, 49) == 0);
         iFlush = ($urandom_range(0, 9) == 0);
         iStall = ($urandom_range(0, 3) == 0);
         iDEC_Valid = ($urandom_range(0, 3) != 0);
         iDEC_RF_Read_Addr_A = 5'($urandom_range(0, 3));
         iDEC_RF_Read_Addr_B = 5'($urandom_range(0, 3));
         iDEC_RF_Read_Data_A = $urandom; iDEC_RF_Read_Data_B = $urandom;
         iDEC_B_Is_Imm = 1'($urandom); iDEC_Imm = $urandom;
         iDEC_Is_ALU = 1'($urandom); iDEC_Is_MULSHLOG = 1'($urandom);
         iDEC_Is_Multiplication = 1'($urandom); iDEC_Is_Shift = 1'($urandom);
         iDEC_ALU_Opcode = 4'($urandom); iDEC_MULSHLOG_Opcode = 3'($urandom);
         iDEC_RF_WriteBack = 2'($urandom); iDEC_RF_Write_Addr = 5'($urandom);
         iDEC_Update_Flag = 1'($urandom); iDEC_Update_P0 = 1'($urandom); iDEC_Update_P1 = 1'($urandom);
         iDEC_PC = 14'($urandom);
         iEX_Fwd_Enable = 1'($urandom); iEX_Fwd_Addr = 5'($urandom_range(0, 3)); iEX_Fwd_Data = $urandom;
         iWB_Enable = 1'($urandom); iWB_Addr = 5'($urandom_range(0, 3)); iWB_Data = $urandom;
         tick();
         checkAll("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
